pc_next_unit: RTL
=================

// Module: pc_next_unit
// PURPOSE
//   Program-counter stage of the single-cycle MIPS32 core. Holds the PC register.
//   Drives the instruction-memory fetch address.
//   Resolves branches (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ), J and JR each cycle.
//   Traps on an illegal next PC, raising the invpc flag.
// PARAMETERS
//   RESET_PC    32'h0040_0000  PC loaded on reset; base of instruction memory
//   IMEM_WORDS  1024           instruction memory depth in words; valid PC range [RESET_PC, RESET_PC+4*IMEM_WORDS)
//   CNT_W       16             width of redirect counter
// PORTS
//   CLK            in   1      clock, rising edge
//   reset          in   1      asynchronous, active-low reset
//   stall          in   1      1 = hold PC this cycle
//   br_type        in   3      0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 reserved
//   jump           in   1      J / JAL
//   jump_reg       in   1      JR
//   rs_val         in   32     register rs value
//   rt_val         in   32     register rt value
//   imm16          in   16     branch offset in words, signed
//   jtarget        in   26     J-type target field
//   pc             out  32     current PC = instruction fetch address
//   pc_plus4       out  32     pc + 4 (for JAL link)
//   branch_taken   out  1      combinational: a redirect is selected this cycle
//   invpc          out  1      sticky: trap taken
//   halted         out  1      1 in TRAP state
//   redirect_count out  CNT_W  number of committed redirects, saturating
// BEHAVIOUR
//   Reset (reset=0, async): state=BOOT, pc=RESET_PC, invpc=0, halted=0, redirect_count=0.
//   FSM states:
//     BOOT: one cycle after reset release; pc held; next state RUN.
//     RUN: pc <= next_pc at each rising CLK unless stall=1; goes to TRAP on an illegal next_pc.
//     TRAP: pc frozen; invpc=1, halted=1; exits only via reset.
//   Branch condition (signed compare on rs_val):
//     BEQ rs==rt; BNE rs!=rt; BLEZ rs<=0; BGTZ rs>0; BLTZ rs<0; BGEZ rs>=0.
//   Branch target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}, mod 2^32 (wrap, no error).
//   Jump target = {pc_plus4[31:28], jtarget, 2'b00}. JR target = rs_val.
//   next_pc priority: jump_reg > jump > taken branch > pc_plus4.
//   branch_taken = selected source != pc_plus4. It is gated by state==RUN and is independent of stall.
//   Illegal next_pc:
//     next_pc[1:0]!=0, or next_pc outside the valid range, or br_type==7 with no jump.
//     Checked only in RUN with stall=0.
//     Effect: no pc update; state->TRAP on that edge.
//   pc_plus4 at the top of the range is illegal on sequential flow.
//   stall=1: pc, state and counter all hold. A pending illegal target does not trap while stalled.
//   redirect_count increments on each RUN, non-stalled, legal redirect edge. It saturates at all-ones.
//   Latency: a redirect decided in cycle N appears on pc in cycle N+1. There is no delay slot.
//   Reset asserted mid-operation, including in TRAP: immediate return to reset values.
// TESTING
//   1. Release reset -> pc=0x00400000 for 2 cycles (BOOT), then 0x00400004 after the next edge with br_type=0.
//   2. pc=0x00400008, BLEZ, rs=0xFFFFFFFC, imm16=0xFFFE -> branch_taken=1; next pc=0x00400004; count+1.
//   3. Same pc, BLEZ, rs=0x00000004 -> branch_taken=0; next pc=0x0040000C. BGTZ with rs=0 -> not taken.
//   4. jump_reg=1, rs=0x00400002 -> invpc=1, halted=1; pc stays; further edges keep pc. Pulse reset low -> pc=0x00400000, invpc=0.
//   5. stall=1 with a taken BEQ (rs=rt=0xAA) for 3 edges -> pc and count unchanged; deassert -> redirect taken.
//   6. Force 2^CNT_W+2 taken jumps to a legal target -> redirect_count saturates at 0xFFFF; jump with jtarget outside the range -> trap.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program-counter stage of the single-cycle MIPS32 core: PC register, branch/jump
// resolution, next-PC legality trap and saturating redirect counter.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       br_type,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jtarget,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             branch_taken,
  output logic             invpc,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  localparam logic [32:0] PC_LO = {1'b0, RESET_PC};
  localparam logic [32:0] PC_HI = PC_LO + 33'(4 * IMEM_WORDS);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             invpc_q, invpc_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] next_pc;
  logic        cond;
  logic        redirect;
  logic        illegal;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pc_plus4[31:28], jtarget, 2'b00};

  always_comb begin
    cond = 1'b0;
    case (br_type)
      3'd1:    cond = (rs_val == rt_val);
      3'd2:    cond = (rs_val != rt_val);
      3'd3:    cond = ($signed(rs_val) <= 32'sd0);
      3'd4:    cond = ($signed(rs_val) >  32'sd0);
      3'd5:    cond = ($signed(rs_val) <  32'sd0);
      3'd6:    cond = ($signed(rs_val) >= 32'sd0);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg)  next_pc = rs_val;
    else if (jump) next_pc = j_target;
    else if (cond) next_pc = br_target;
  end

  // A redirect that happens to land on pc+4 is indistinguishable from sequential flow.
  assign redirect     = (next_pc != pc_plus4);
  assign branch_taken = (state_q == RUN) && redirect;

  assign illegal = (next_pc[1:0] != 2'b00)
                || ({1'b0, next_pc} < PC_LO)
                || ({1'b0, next_pc} >= PC_HI)
                || ((br_type == 3'd7) && !jump && !jump_reg);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    invpc_d  = invpc_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!stall) begin
          if (illegal) begin
            state_d  = TRAP;
            invpc_d  = 1'b1;
            halted_d = 1'b1;
          end else begin
            pc_d = next_pc;
            if (redirect && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TRAP: begin
        invpc_d  = 1'b1;
        halted_d = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      invpc_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      invpc_q  <= invpc_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pc             = pc_q;
  assign invpc          = invpc_q;
  assign halted         = halted_q;
  assign redirect_count = cnt_q;

endmodule
